// File: rtl/dbx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dbx_arbiter
// Purpose  : Round-robin scheduler sharing one combinational DBX transform
//            among NUM_REQ compressor lanes. The grant is locked for a whole
//            burst so beats of a line stay contiguous. The transformed beat
//            is captured in a single output register with valid/ready.
// Ports    : clk, rst           clock, asynchronous active-high reset
//            req_valid_i        per-lane beat valid
//            req_last_i         per-lane last-beat-of-burst flag
//            req_data_i         per-lane 256-bit difference block (lane k at
//                               [k*256 +: 256])
//            req_ready_o        per-lane accept (one-hot or zero)
//            bpx_valid_o/ready  output handshake
//            bpx_o              registered DBX result
//            bpx_id_o           lane that produced bpx_o
//            bpx_last_o         registered last flag
//            err_o              sticky: a burst exceeded MAX_BEATS
// Revision : 1.0 - initial release
// ============================================================================
module dbx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 2,
  parameter int ID_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  input  logic [NUM_REQ*256-1:0] req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   bpx_valid_o,
  input  logic                   bpx_ready_i,
  output logic [255:0]           bpx_o,
  output logic [ID_W-1:0]        bpx_id_o,
  output logic                   bpx_last_o,
  output logic                   err_o
);

  localparam int              CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] C_ONE_CNT = CNT_W'(1);
  localparam logic [ID_W:0]    C_NUM_REQ = (ID_W+1)'(NUM_REQ);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]   r_lock_id, w_lock_id_nxt;
  logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt, w_cnt_inc;
  logic              w_err_set;

  logic              w_slot_free;
  logic [NUM_REQ-1:0] w_rot;
  logic [ID_W-1:0]   w_off;
  logic              w_found;
  logic [ID_W:0]     w_sum;
  logic [ID_W:0]     w_inc;
  logic [ID_W-1:0]   w_grant;
  logic [ID_W-1:0]   w_grant_inc;
  logic              w_accept;
  logic              w_sel_last;
  logic [255:0]      w_sel_data;
  logic [7:0][31:0]  w_plane;
  logic [255:0]      w_dbx;

  assign w_slot_free = !bpx_valid_o || bpx_ready_i;

  // --------------------------------------------------------------------------
  // Grant selection. In IDLE the valid vector is rotated so that rr_ptr sits
  // at bit 0; the lowest set bit is then the first requester in round-robin
  // order. In LOCK the grant is pinned to the burst owner.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rot   = NUM_REQ'({req_valid_i, req_valid_i} >> r_rr_ptr);
    w_off   = '0;
    w_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = ID_W'(i);
        w_found = 1'b1;
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= C_NUM_REQ) begin
      w_sum = w_sum - C_NUM_REQ;
    end
    if (r_state == S_LOCK) begin
      w_grant = r_lock_id;
    end else begin
      w_grant = w_sum[ID_W-1:0];
    end
  end

  // Next round-robin start: one past the lane completing its burst.
  always_comb begin
    w_inc = {1'b0, w_grant} + {{ID_W{1'b0}}, 1'b1};
    if (w_inc == C_NUM_REQ) begin
      w_inc = '0;
    end
    w_grant_inc = w_inc[ID_W-1:0];
  end

  // Ready is driven only from valid, state and the output slot, never data.
  always_comb begin
    req_ready_o = '0;
    if (w_slot_free && req_valid_i[w_grant] && (r_state == S_LOCK || w_found)) begin
      req_ready_o[w_grant] = 1'b1;
    end
  end

  assign w_accept   = |req_ready_o;
  assign w_sel_last = req_last_i[w_grant];
  assign w_sel_data = req_data_i[w_grant*256 +: 256];

  // --------------------------------------------------------------------------
  // DBX transform. The block is 32 bytes, byte 0 at [255:248]. Plane p holds
  // bit p of every byte, byte b landing at plane bit 31-b. Output slot j
  // ([255-32j -: 32]) carries plane 7-j. The top plane passes raw; each lower
  // plane is XORed with the plane above it, except the byte-0 column, which
  // is the base symbol and is kept raw in every plane.
  // --------------------------------------------------------------------------
  always_comb begin
    w_plane = '0;
    for (int p = 0; p < 8; p++) begin
      for (int b = 0; b < 32; b++) begin
        w_plane[p][31-b] = w_sel_data[248 - 8*b + p];
      end
    end
    w_dbx = '0;
    w_dbx[255 -: 32] = w_plane[7];
    for (int j = 1; j < 8; j++) begin
      w_dbx[255 - 32*j -: 32] = w_plane[7-j] ^ {1'b0, w_plane[8-j][30:0]};
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and burst bookkeeping.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_id_nxt  = r_lock_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_err_set      = 1'b0;

    // Count of beats after this non-last beat, saturating at MAX_BEATS.
    if (r_state == S_IDLE) begin
      w_cnt_inc = C_ONE_CNT;
    end else if (r_beat_cnt >= C_MAX_CNT) begin
      w_cnt_inc = C_MAX_CNT;
    end else begin
      w_cnt_inc = r_beat_cnt + C_ONE_CNT;
    end

    if (w_accept) begin
      if (w_sel_last) begin
        w_state_nxt    = S_IDLE;
        w_rr_ptr_nxt   = w_grant_inc;
        w_beat_cnt_nxt = '0;
      end else begin
        w_state_nxt    = S_LOCK;
        w_lock_id_nxt  = w_grant;
        w_beat_cnt_nxt = w_cnt_inc;
        // A non-last beat reaching the limit means the last beat is missing.
        if (w_cnt_inc == C_MAX_CNT) begin
          w_err_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_lock_id  <= w_lock_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Output register stage and sticky error.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpx_valid_o <= 1'b0;
      bpx_o       <= '0;
      bpx_id_o    <= '0;
      bpx_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (w_err_set) begin
        err_o <= 1'b1;
      end
      if (w_slot_free) begin
        bpx_valid_o <= w_accept;
        if (w_accept) begin
          bpx_o      <= w_dbx;
          bpx_id_o   <= w_grant;
          bpx_last_o <= w_sel_last;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dbx_arbiter
// Purpose  : Directed self-checking bench for dbx_arbiter (NUM_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_last  = '0;
  logic [NUM_REQ*256-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   bpx_valid;
  logic                   bpx_ready = 1'b1;
  logic [255:0]           bpx;
  logic [ID_W-1:0]        bpx_id;
  logic                   bpx_last;
  logic                   err;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [255:0] C_BYTE0_FF = {8{32'h8000_0000}};
  localparam logic [255:0] C_BYTE1_FF = {32'h4000_0000, 224'h0};

  dbx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BEATS(2), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .bpx_valid_o (bpx_valid),
    .bpx_ready_i (bpx_ready),
    .bpx_o       (bpx),
    .bpx_id_o    (bpx_id),
    .bpx_last_o  (bpx_last),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    bpx_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bpx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bpx_valid); end
    n_cmp++; if (bpx !== 256'h0) begin n_fail++; $display("FAIL reset_bpx: got %h want 0", bpx); end
    n_cmp++; if (bpx_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bpx_id); end
    n_cmp++; if (bpx_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", bpx_last); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_inputs();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    req_data[2*256+255 -: 8] = 8'hFF;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (bpx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bpx_valid); end
    n_cmp++; if (bpx_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", bpx_id); end
    n_cmp++; if (bpx_last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", bpx_last); end
    n_cmp++; if (bpx !== C_BYTE0_FF) begin n_fail++; $display("FAIL single_bpx: got %h want %h", bpx, C_BYTE0_FF); end
    // rr_ptr should now be 3: with lanes 0 and 3 requesting, lane 3 wins.
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_rrptr: got %b want 1000", req_ready); end
    req_valid = '0;
    tick();
    n_cmp++; if (bpx_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: got %b want 0", bpx_valid); end
  endtask

  task automatic test_xor();
    clear_inputs();
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    req_data[247 -: 8] = 8'hFF;
    tick();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    req_data  = '0;
    #1;
    n_cmp++; if (bpx !== C_BYTE1_FF) begin n_fail++; $display("FAIL xor_byte1: got %h want %h", bpx, C_BYTE1_FF); end
    n_cmp++; if (bpx_id !== 2'd0) begin n_fail++; $display("FAIL xor_id0: got %0d want 0", bpx_id); end
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (bpx !== 256'h0) begin n_fail++; $display("FAIL xor_zero: got %h want 0", bpx); end
    n_cmp++; if (bpx_id !== 2'd1 || bpx_valid !== 1'b1) begin n_fail++; $display("FAIL xor_id1: got id %0d valid %b want id 1 valid 1", bpx_id, bpx_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    apply_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_id  = 2'(i % 4);
      exp_rdy = 4'b0001 << exp_id;
      #1;
      n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp_rdy); end
      tick();
      n_cmp++; if (bpx_id !== exp_id || bpx_valid !== 1'b1) begin n_fail++; $display("FAIL rr_id[%0d]: got id %0d valid %b want id %0d valid 1", i, bpx_id, bpx_valid, exp_id); end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_burst_lock();
    apply_reset();
    // Lane 0 single beat moves rr_ptr to 1.
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    tick();
    n_cmp++; if (bpx_id !== 2'd0) begin n_fail++; $display("FAIL lock_pre_id: got %0d want 0", bpx_id); end
    req_valid = 4'b0011;
    req_last  = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_beat1_ready: got %b want 0010", req_ready); end
    tick();
    n_cmp++; if (bpx_id !== 2'd1 || bpx_last !== 1'b0) begin n_fail++; $display("FAIL lock_beat1_out: got id %0d last %b want id 1 last 0", bpx_id, bpx_last); end
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_gap_ready[%0d]: got %b want 0000", i, req_ready); end
      tick();
      n_cmp++; if (bpx_valid !== 1'b0) begin n_fail++; $display("FAIL lock_gap_valid[%0d]: got %b want 0", i, bpx_valid); end
    end
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_beat2_ready: got %b want 0010", req_ready); end
    tick();
    n_cmp++; if (bpx_id !== 2'd1 || bpx_last !== 1'b1) begin n_fail++; $display("FAIL lock_beat2_out: got id %0d last %b want id 1 last 1", bpx_id, bpx_last); end
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_after_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (bpx_id !== 2'd0 || bpx_valid !== 1'b1) begin n_fail++; $display("FAIL lock_after_id: got id %0d valid %b want id 0 valid 1", bpx_id, bpx_valid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lock_err: got %b want 0", err); end
    tick();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    req_data[2*256+255 -: 8] = 8'hFF;
    req_data[3*256+247 -: 8] = 8'hFF;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_first_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    bpx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", i, req_ready); end
      n_cmp++; if (bpx_valid !== 1'b1 || bpx_id !== 2'd2 || bpx !== C_BYTE0_FF) begin n_fail++; $display("FAIL bp_hold_out[%0d]: got valid %b id %0d bpx %h want valid 1 id 2 bpx %h", i, bpx_valid, bpx_id, bpx, C_BYTE0_FF); end
      tick();
    end
    bpx_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (bpx_id !== 2'd3 || bpx !== C_BYTE1_FF || bpx_last !== 1'b1) begin n_fail++; $display("FAIL bp_release_out: got id %0d last %b bpx %h want id 3 last 1 bpx %h", bpx_id, bpx_last, bpx, C_BYTE1_FF); end
    tick();
    n_cmp++; if (bpx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got valid %b want 0", bpx_valid); end
  endtask

  task automatic test_error_reset();
    clear_inputs();
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL err_beat1_ready: got %b want 1000", req_ready); end
    tick();
    n_cmp++; if (err !== 1'b0 || bpx_id !== 2'd3 || bpx_last !== 1'b0) begin n_fail++; $display("FAIL err_beat1: got err %b id %0d last %b want err 0 id 3 last 0", err, bpx_id, bpx_last); end
    req_valid = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL err_locked_ready: got %b want 1000", req_ready); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_beat2: got %b want 1", err); end
    tick();
    n_cmp++; if (err !== 1'b1 || bpx_id !== 2'd3) begin n_fail++; $display("FAIL err_beat3: got err %b id %0d want err 1 id 3", err, bpx_id); end
    // Asynchronous reset in the middle of the clock period, burst still open.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bpx_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags: got valid %b err %b want 0 0", bpx_valid, err); end
    n_cmp++; if (bpx !== 256'h0 || bpx_id !== 2'd0 || bpx_last !== 1'b0) begin n_fail++; $display("FAIL async_rst_data: got bpx %h id %0d last %b want 0", bpx, bpx_id, bpx_last); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL async_rst_idle: got %b want 0001", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_xor();
    test_fairness();
    test_burst_lock();
    test_backpressure();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
